// File: rtl/axil_sensor_ctrl_slave.sv
// AXI4-Lite register slave for a sensor power-up controller (ID, CTRL, STAT, SCRATCH).
// Latency: write commits one cycle after both AW and W are latched; read data one cycle after the AR handshake.
// Backpressure: bvalid/rvalid hold until accepted; no new AW/W is taken while a write response is pending, and no new AR while read data is pending.
//
// Ports:
//   axiClk100MHz, axiReset_n         - clock, synchronous active-low reset
//   s_axil_if_aw*/w*/b*              - AXI4-Lite write address/data/response channels
//   s_axil_if_ar*/r*                 - AXI4-Lite read address/data channels
//   sensor_clk_en, sensor_reset_n    - sensor controls derived from CTRL[1:0]
//   sensor_ready                     - power-up sequence complete (STAT[0])
module axil_sensor_ctrl_slave #(
    parameter logic [31:0] ID_VALUE      = 32'h0058_0001,
    parameter int unsigned POWERUP_DELAY = 16
) (
    input  logic        axiClk100MHz,
    input  logic        axiReset_n,
    input  logic [31:0] s_axil_if_awaddr,
    input  logic [2:0]  s_axil_if_awprot,
    input  logic        s_axil_if_awvalid,
    output logic        s_axil_if_awready,
    input  logic [31:0] s_axil_if_wdata,
    input  logic [3:0]  s_axil_if_wstrb,
    input  logic        s_axil_if_wvalid,
    output logic        s_axil_if_wready,
    output logic [1:0]  s_axil_if_bresp,
    output logic        s_axil_if_bvalid,
    input  logic        s_axil_if_bready,
    input  logic [31:0] s_axil_if_araddr,
    input  logic [2:0]  s_axil_if_arprot,
    input  logic        s_axil_if_arvalid,
    output logic        s_axil_if_arready,
    output logic [31:0] s_axil_if_rdata,
    output logic [1:0]  s_axil_if_rresp,
    output logic        s_axil_if_rvalid,
    input  logic        s_axil_if_rready,
    output logic        sensor_clk_en,
    output logic        sensor_reset_n,
    output logic        sensor_ready
);

    localparam logic [10:0] ADDR_ID      = 11'h000;
    localparam logic [10:0] ADDR_CTRL    = 11'h190;
    localparam logic [10:0] ADDR_STAT    = 11'h198;
    localparam logic [10:0] ADDR_SCRATCH = 11'h1A0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [15:0] CNT_LAST = 16'(POWERUP_DELAY - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_COUNT = 2'd1,
        ST_READY = 2'd2
    } pwr_state_t;

    // Protection bits and upper address bits carry no meaning for this block.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, s_axil_if_awprot, s_axil_if_arprot,
                             s_axil_if_awaddr[31:11], s_axil_if_araddr[31:11]};

    // Ready outputs stay low until the first clock edge after reset release.
    logic        init_done_q;

    logic        aw_vld_q;
    logic [10:0] awaddr_q;
    logic        w_vld_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;

    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    logic [1:0]  ctrl_q;
    logic [31:0] scratch_q;

    pwr_state_t  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    logic        aw_hs, w_hs, ar_hs, do_write;
    logic        wr_ok, wr_ctrl, wr_scratch;
    logic [31:0] scratch_wr_val;
    logic        rd_ok;
    logic [31:0] rd_data;
    logic [31:0] stat_val;
    logic        pwr_on;

    assign s_axil_if_awready = init_done_q && !aw_vld_q && !bvalid_q;
    assign s_axil_if_wready  = init_done_q && !w_vld_q  && !bvalid_q;
    assign s_axil_if_arready = init_done_q && !rvalid_q;

    assign aw_hs    = s_axil_if_awvalid && s_axil_if_awready;
    assign w_hs     = s_axil_if_wvalid  && s_axil_if_wready;
    assign ar_hs    = s_axil_if_arvalid && s_axil_if_arready;
    assign do_write = aw_vld_q && w_vld_q && !bvalid_q;

    assign s_axil_if_bvalid = bvalid_q;
    assign s_axil_if_bresp  = bresp_q;
    assign s_axil_if_rvalid = rvalid_q;
    assign s_axil_if_rdata  = rdata_q;
    assign s_axil_if_rresp  = rresp_q;

    assign sensor_clk_en  = ctrl_q[1];
    assign sensor_reset_n = ctrl_q[0] & ctrl_q[1];
    assign sensor_ready   = (state_q == ST_READY);

    assign stat_val = {cnt_q, 15'b0, sensor_ready};
    assign pwr_on   = (ctrl_q == 2'b11);

    // Write decode on the latched address; ID and STAT are read-only.
    always_comb begin
        wr_ok      = 1'b0;
        wr_ctrl    = 1'b0;
        wr_scratch = 1'b0;
        case (awaddr_q)
            ADDR_CTRL: begin
                wr_ok   = 1'b1;
                wr_ctrl = 1'b1;
            end
            ADDR_SCRATCH: begin
                wr_ok      = 1'b1;
                wr_scratch = 1'b1;
            end
            default: wr_ok = 1'b0;
        endcase
    end

    always_comb begin
        scratch_wr_val = scratch_q;
        for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) begin
                scratch_wr_val[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    // Read decode samples current register values, so a same-cycle write is not visible.
    always_comb begin
        rd_ok   = 1'b1;
        rd_data = '0;
        case (s_axil_if_araddr[10:0])
            ADDR_ID:      rd_data = ID_VALUE;
            ADDR_CTRL:    rd_data = {30'b0, ctrl_q};
            ADDR_STAT:    rd_data = stat_val;
            ADDR_SCRATCH: rd_data = scratch_q;
            default:      rd_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge axiClk100MHz) begin
        if (!axiReset_n) begin
            init_done_q <= 1'b0;
            aw_vld_q    <= 1'b0;
            awaddr_q    <= '0;
            w_vld_q     <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            ctrl_q      <= '0;
            scratch_q   <= '0;
        end else begin
            init_done_q <= 1'b1;

            if (aw_hs) begin
                aw_vld_q <= 1'b1;
                awaddr_q <= s_axil_if_awaddr[10:0];
            end
            if (w_hs) begin
                w_vld_q <= 1'b1;
                wdata_q <= s_axil_if_wdata;
                wstrb_q <= s_axil_if_wstrb;
            end

            // The latches are freed at commit; bvalid alone then holds off new AW/W.
            if (do_write) begin
                aw_vld_q <= 1'b0;
                w_vld_q  <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_ctrl && wstrb_q[0]) begin
                    ctrl_q <= wdata_q[1:0];
                end
                if (wr_scratch) begin
                    scratch_q <= scratch_wr_val;
                end
            end else if (bvalid_q && s_axil_if_bready) begin
                bvalid_q <= 1'b0;
            end

            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid_q && s_axil_if_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Power-up sequencer: the counter runs 0..POWERUP_DELAY-1 in COUNT, so READY
    // arrives POWERUP_DELAY cycles after COUNT is entered. Dropping either CTRL bit
    // returns to OFF from any state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (pwr_on) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!pwr_on) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_READY: begin
                if (!pwr_on) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge axiClk100MHz) begin
        if (!axiReset_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axil_sensor_ctrl_slave.sv
module tb_axil_sensor_ctrl_slave;

    logic        axiClk100MHz = 1'b0;
    logic        axiReset_n   = 1'b0;
    logic [31:0] s_axil_if_awaddr  = '0;
    logic [2:0]  s_axil_if_awprot  = '0;
    logic        s_axil_if_awvalid = 1'b0;
    logic        s_axil_if_awready;
    logic [31:0] s_axil_if_wdata   = '0;
    logic [3:0]  s_axil_if_wstrb   = '0;
    logic        s_axil_if_wvalid  = 1'b0;
    logic        s_axil_if_wready;
    logic [1:0]  s_axil_if_bresp;
    logic        s_axil_if_bvalid;
    logic        s_axil_if_bready  = 1'b0;
    logic [31:0] s_axil_if_araddr  = '0;
    logic [2:0]  s_axil_if_arprot  = '0;
    logic        s_axil_if_arvalid = 1'b0;
    logic        s_axil_if_arready;
    logic [31:0] s_axil_if_rdata;
    logic [1:0]  s_axil_if_rresp;
    logic        s_axil_if_rvalid;
    logic        s_axil_if_rready  = 1'b0;
    logic        sensor_clk_en;
    logic        sensor_reset_n;
    logic        sensor_ready;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    axil_sensor_ctrl_slave dut (
        .axiClk100MHz      (axiClk100MHz),
        .axiReset_n        (axiReset_n),
        .s_axil_if_awaddr  (s_axil_if_awaddr),
        .s_axil_if_awprot  (s_axil_if_awprot),
        .s_axil_if_awvalid (s_axil_if_awvalid),
        .s_axil_if_awready (s_axil_if_awready),
        .s_axil_if_wdata   (s_axil_if_wdata),
        .s_axil_if_wstrb   (s_axil_if_wstrb),
        .s_axil_if_wvalid  (s_axil_if_wvalid),
        .s_axil_if_wready  (s_axil_if_wready),
        .s_axil_if_bresp   (s_axil_if_bresp),
        .s_axil_if_bvalid  (s_axil_if_bvalid),
        .s_axil_if_bready  (s_axil_if_bready),
        .s_axil_if_araddr  (s_axil_if_araddr),
        .s_axil_if_arprot  (s_axil_if_arprot),
        .s_axil_if_arvalid (s_axil_if_arvalid),
        .s_axil_if_arready (s_axil_if_arready),
        .s_axil_if_rdata   (s_axil_if_rdata),
        .s_axil_if_rresp   (s_axil_if_rresp),
        .s_axil_if_rvalid  (s_axil_if_rvalid),
        .s_axil_if_rready  (s_axil_if_rready),
        .sensor_clk_en     (sensor_clk_en),
        .sensor_reset_n    (sensor_reset_n),
        .sensor_ready      (sensor_ready)
    );

    always #5 axiClk100MHz = ~axiClk100MHz;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // AW is raised aw_dly cycles after W; bready is held low for b_hold cycles once bvalid appears.
    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int b_hold, input logic [1:0] hold_resp,
                          output logic [1:0] resp, output logic ok);
        bit aw_done, w_done;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        s_axil_if_awaddr  = a;
        s_axil_if_wdata   = d;
        s_axil_if_wstrb   = s;
        s_axil_if_wvalid  = 1'b1;
        s_axil_if_awvalid = (aw_dly == 0);
        s_axil_if_bready  = (b_hold == 0);
        while (!(aw_done && w_done) && n < 40) begin
            @(negedge axiClk100MHz);
            if (s_axil_if_awvalid && s_axil_if_awready) aw_done = 1;
            if (s_axil_if_wvalid && s_axil_if_wready) w_done = 1;
            @(posedge axiClk100MHz); #1;
            n++;
            if (aw_done) s_axil_if_awvalid = 1'b0;
            if (w_done) s_axil_if_wvalid = 1'b0;
            if (!aw_done && n >= aw_dly) s_axil_if_awvalid = 1'b1;
        end
        n = 0;
        do begin
            @(negedge axiClk100MHz);
            n++;
        end while (!s_axil_if_bvalid && n < 40);
        ok   = s_axil_if_bvalid;
        resp = s_axil_if_bresp;
        for (int i = 0; i < b_hold; i++) begin
            @(negedge axiClk100MHz);
            chk("bhold_bvalid", s_axil_if_bvalid, 1'b1);
            chk("bhold_bresp", s_axil_if_bresp, hold_resp);
            chk("bhold_awready", s_axil_if_awready, 1'b0);
        end
        s_axil_if_bready = 1'b1;
        @(posedge axiClk100MHz); #1;
        s_axil_if_bready  = 1'b0;
        s_axil_if_awvalid = 1'b0;
        s_axil_if_wvalid  = 1'b0;
    endtask

    task automatic axi_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                          output int lat);
        bit done;
        int n;
        done = 0; n = 0;
        s_axil_if_araddr  = a;
        s_axil_if_arvalid = 1'b1;
        while (!done && n < 40) begin
            @(negedge axiClk100MHz);
            if (s_axil_if_arready) done = 1;
            @(posedge axiClk100MHz); #1;
            n++;
        end
        s_axil_if_arvalid = 1'b0;
        lat = 0;
        do begin
            @(negedge axiClk100MHz);
            lat++;
        end while (!s_axil_if_rvalid && lat < 40);
        d = s_axil_if_rdata;
        r = s_axil_if_rresp;
        s_axil_if_rready = 1'b1;
        @(posedge axiClk100MHz); #1;
        s_axil_if_rready = 1'b0;
    endtask

    task automatic do_reset();
        axiReset_n = 1'b0;
        repeat (3) @(posedge axiClk100MHz);
        #1;
        axiReset_n = 1'b1;
    endtask

    logic [31:0] rd_d;
    logic [1:0]  rd_r;
    int          rd_lat;
    logic [1:0]  wr_r;
    logic        wr_ok;

    initial begin
        // Reset state
        repeat (2) @(posedge axiClk100MHz);
        @(negedge axiClk100MHz);
        chk("rst_handshake", {s_axil_if_awready, s_axil_if_wready, s_axil_if_arready,
                              s_axil_if_bvalid, s_axil_if_rvalid}, 5'b00000);
        chk("rst_sensor", {sensor_clk_en, sensor_reset_n, sensor_ready}, 3'b000);
        @(posedge axiClk100MHz); #1;
        axiReset_n = 1'b1;
        @(negedge axiClk100MHz);
        chk("rdy_before_edge", {s_axil_if_awready, s_axil_if_wready, s_axil_if_arready}, 3'b000);
        @(negedge axiClk100MHz);
        chk("rdy_after_edge", {s_axil_if_awready, s_axil_if_wready, s_axil_if_arready}, 3'b111);

        // ID and aliasing of upper address bits
        axi_rd(32'h0000_0000, rd_d, rd_r, rd_lat);
        chk("id_data", rd_d, 32'h0058_0001);
        chk("id_resp", rd_r, OKAY);
        chk("id_latency", rd_lat, 1);
        axi_rd(32'h1234_5800, rd_d, rd_r, rd_lat);
        chk("id_alias", rd_d, 32'h0058_0001);
        axi_rd(32'h198, rd_d, rd_r, rd_lat);
        chk("stat_reset", rd_d, 32'h0);
        chk("stat_reset_resp", rd_r, OKAY);
        axi_rd(32'h1A0, rd_d, rd_r, rd_lat);
        chk("scratch_reset", rd_d, 32'h0);

        // Power-up: COUNT entered one edge after the CTRL commit, READY 16 edges later
        axi_wr(32'h190, 32'h3, 4'h1, 0, 0, OKAY, wr_r, wr_ok);
        chk("ctrl_wr_ok", wr_ok, 1'b1);
        chk("ctrl_wr_resp", wr_r, OKAY);
        chk("clk_en_on", sensor_clk_en, 1'b1);
        chk("reset_n_on", sensor_reset_n, 1'b1);
        repeat (16) @(negedge axiClk100MHz);
        chk("ready_cnt15", sensor_ready, 1'b0);
        @(negedge axiClk100MHz);
        chk("ready_cnt16", sensor_ready, 1'b1);
        axi_rd(32'h198, rd_d, rd_r, rd_lat);
        chk("stat_ready_low", rd_d & 32'h0000_FFFF, 32'h1);
        axi_rd(32'h190, rd_d, rd_r, rd_lat);
        chk("ctrl_read", rd_d, 32'h3);

        // W three cycles ahead of AW, sparse strobes
        axi_wr(32'h1A0, 32'hDEAD_BEEF, 4'h5, 3, 0, OKAY, wr_r, wr_ok);
        chk("wlead_resp", wr_r, OKAY);
        axi_rd(32'h1A0, rd_d, rd_r, rd_lat);
        chk("wlead_data", rd_d, 32'h00AD_00EF);

        // Zero strobes: OKAY, nothing changes
        axi_wr(32'h1A0, 32'h1234_5678, 4'h0, 0, 0, OKAY, wr_r, wr_ok);
        chk("strb0_resp", wr_r, OKAY);
        axi_rd(32'h1A0, rd_d, rd_r, rd_lat);
        chk("strb0_data", rd_d, 32'h00AD_00EF);
        axi_wr(32'h190, 32'h0, 4'h0, 0, 0, OKAY, wr_r, wr_ok);
        chk("ctrl_strb0_ready", sensor_ready, 1'b1);

        // Writes to read-only and unmapped offsets
        axi_wr(32'h198, 32'hFFFF_FFFF, 4'hF, 0, 0, OKAY, wr_r, wr_ok);
        chk("stat_wr_resp", wr_r, SLVERR);
        axi_rd(32'h198, rd_d, rd_r, rd_lat);
        chk("stat_unchanged", rd_d & 32'h0000_FFFF, 32'h1);
        axi_rd(32'h300, rd_d, rd_r, rd_lat);
        chk("unmapped_rdata", rd_d, 32'h0);
        chk("unmapped_rresp", rd_r, SLVERR);
        axi_wr(32'h000, 32'hFFFF_FFFF, 4'hF, 0, 0, OKAY, wr_r, wr_ok);
        chk("id_wr_resp", wr_r, SLVERR);
        axi_rd(32'h000, rd_d, rd_r, rd_lat);
        chk("id_unchanged", rd_d, 32'h0058_0001);

        // Response held while bready is low
        axi_wr(32'h7FC, 32'hA5A5_A5A5, 4'hF, 0, 10, SLVERR, wr_r, wr_ok);
        chk("bhold_resp", wr_r, SLVERR);
        @(negedge axiClk100MHz);
        chk("bhold_release", {s_axil_if_bvalid, s_axil_if_awready}, 2'b01);

        // Read commits on the same edge as a write to the same register
        fork
            axi_wr(32'h1A0, 32'h1111_1111, 4'hF, 0, 0, OKAY, wr_r, wr_ok);
            begin
                @(posedge axiClk100MHz); #1;
                axi_rd(32'h1A0, rd_d, rd_r, rd_lat);
            end
        join
        chk("concurrent_old", rd_d, 32'h00AD_00EF);
        chk("concurrent_wresp", wr_r, OKAY);
        axi_rd(32'h1A0, rd_d, rd_r, rd_lat);
        chk("concurrent_new", rd_d, 32'h1111_1111);

        // Power-down from READY
        chk("ready_before_off", sensor_ready, 1'b1);
        axi_wr(32'h190, 32'h1, 4'h1, 0, 0, OKAY, wr_r, wr_ok);
        chk("off_clk_en", sensor_clk_en, 1'b0);
        chk("off_reset_n", sensor_reset_n, 1'b0);
        @(negedge axiClk100MHz);
        chk("off_ready", sensor_ready, 1'b0);
        axi_rd(32'h190, rd_d, rd_r, rd_lat);
        chk("off_ctrl", rd_d, 32'h1);
        axi_rd(32'h198, rd_d, rd_r, rd_lat);
        chk("off_stat", rd_d, 32'h0);

        // Reset with only W latched: the data must be discarded
        s_axil_if_wdata  = 32'hFFFF_FFFF;
        s_axil_if_wstrb  = 4'hF;
        s_axil_if_wvalid = 1'b1;
        @(negedge axiClk100MHz);
        chk("midrst_wready", s_axil_if_wready, 1'b1);
        @(posedge axiClk100MHz); #1;
        s_axil_if_wvalid = 1'b0;
        do_reset();
        repeat (2) @(negedge axiClk100MHz);
        chk("midrst_ready", {s_axil_if_awready, s_axil_if_wready, s_axil_if_bvalid}, 3'b110);
        axi_rd(32'h1A0, rd_d, rd_r, rd_lat);
        chk("midrst_scratch", rd_d, 32'h0);
        s_axil_if_awaddr  = 32'h1A0;
        s_axil_if_awvalid = 1'b1;
        @(posedge axiClk100MHz); #1;
        s_axil_if_awvalid = 1'b0;
        repeat (5) @(negedge axiClk100MHz);
        chk("midrst_no_bvalid", s_axil_if_bvalid, 1'b0);
        s_axil_if_wdata  = 32'h0000_00A5;
        s_axil_if_wstrb  = 4'h1;
        s_axil_if_wvalid = 1'b1;
        @(posedge axiClk100MHz); #1;
        s_axil_if_wvalid = 1'b0;
        @(posedge axiClk100MHz);
        @(negedge axiClk100MHz);
        chk("aw_first_bvalid", {s_axil_if_bvalid, s_axil_if_bresp}, {1'b1, OKAY});
        s_axil_if_bready = 1'b1;
        @(posedge axiClk100MHz); #1;
        s_axil_if_bready = 1'b0;
        axi_rd(32'h1A0, rd_d, rd_r, rd_lat);
        chk("aw_first_data", rd_d, 32'h0000_00A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
